// File: rtl/layer_mixer.sv
`default_nettype none
// ============================================================================
// Module   : layer_mixer
// Purpose  : N-layer priority pixel compositor with per-frame pairwise
//            layer-overlap (collision) monitor, two-stage pipeline on clk_vga.
// Revision : 1.0 - initial release
// ============================================================================
module layer_mixer #(
    parameter int                NUM_LAYERS  = 4,
    parameter int                RGB_W       = 12,
    parameter logic [RGB_W-1:0]  BG_RGB      = '0,
    parameter int                FRAME_CNT_W = 16
) (
    input  logic                             clk_vga,
    input  logic                             rst,
    input  logic                             disp_i,
    input  logic                             v_sync_i,
    input  logic [NUM_LAYERS-1:0]            layer_en_i,
    input  logic [NUM_LAYERS*RGB_W-1:0]      rgb_i,
    input  logic [NUM_LAYERS-1:0]            alpha_i,
    output logic [RGB_W-1:0]                 rgb_o,
    output logic                             disp_o,
    output logic [NUM_LAYERS*NUM_LAYERS-1:0] hit_pulse_o,
    output logic [NUM_LAYERS*NUM_LAYERS-1:0] frame_hits_o,
    output logic [FRAME_CNT_W-1:0]           frame_cnt_o
);

    localparam int NPAIR = NUM_LAYERS * NUM_LAYERS;

    logic [NUM_LAYERS*RGB_W-1:0] rgb_q;
    logic [NUM_LAYERS-1:0]       opq_q;
    logic                        disp_q;
    logic                        vs_q;
    logic                        vs_prev_q;

    logic [RGB_W-1:0]            pix_d,        pix_q;
    logic                        disp_o_q;
    logic [NPAIR-1:0]            pulse_d,      pulse_q;
    logic [NPAIR-1:0]            seen_d,       seen_q;
    logic [NPAIR-1:0]            frame_hits_d, frame_hits_q;
    logic [FRAME_CNT_W-1:0]      frame_cnt_d,  frame_cnt_q;

    logic [NPAIR-1:0]            hit_now;
    logic                        boundary;

    // v_sync idles high, so both edge-detector taps reset to 1 to avoid a
    // spurious boundary right after reset.
    always_ff @(posedge clk_vga or negedge rst) begin
        if (!rst) begin
            rgb_q     <= '0;
            opq_q     <= '0;
            disp_q    <= 1'b0;
            vs_q      <= 1'b1;
            vs_prev_q <= 1'b1;
        end else begin
            rgb_q     <= rgb_i;
            opq_q     <= alpha_i & layer_en_i & {NUM_LAYERS{disp_i}};
            disp_q    <= disp_i;
            vs_q      <= v_sync_i;
            vs_prev_q <= vs_q;
        end
    end

    genvar gi, gj;
    generate
        for (gi = 0; gi < NUM_LAYERS; gi++) begin : g_row
            for (gj = 0; gj < NUM_LAYERS; gj++) begin : g_col
                if (gi < gj) begin : g_pair
                    assign hit_now[gi*NUM_LAYERS+gj] = opq_q[gi] & opq_q[gj];
                end else begin : g_tie
                    assign hit_now[gi*NUM_LAYERS+gj] = 1'b0;
                end
            end
        end
    endgenerate

    assign boundary = vs_prev_q & ~vs_q;

    always_comb begin
        pix_d = disp_q ? BG_RGB : '0;
        // Descending scan so the lowest opaque index is applied last and wins.
        for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
            if (opq_q[k]) begin
                pix_d = rgb_q[k*RGB_W +: RGB_W];
            end
        end

        pulse_d      = hit_now & ~seen_q;
        seen_d       = seen_q | hit_now;
        frame_hits_d = frame_hits_q;
        frame_cnt_d  = frame_cnt_q;
        if (boundary) begin
            // A boundary-cycle hit belongs to the ending frame only.
            frame_hits_d = seen_q | hit_now;
            seen_d       = '0;
            frame_cnt_d  = frame_cnt_q + FRAME_CNT_W'(1);
        end
    end

    always_ff @(posedge clk_vga or negedge rst) begin
        if (!rst) begin
            pix_q        <= '0;
            disp_o_q     <= 1'b0;
            pulse_q      <= '0;
            seen_q       <= '0;
            frame_hits_q <= '0;
            frame_cnt_q  <= '0;
        end else begin
            pix_q        <= pix_d;
            disp_o_q     <= disp_q;
            pulse_q      <= pulse_d;
            seen_q       <= seen_d;
            frame_hits_q <= frame_hits_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign rgb_o        = pix_q;
    assign disp_o       = disp_o_q;
    assign hit_pulse_o  = pulse_q;
    assign frame_hits_o = frame_hits_q;
    assign frame_cnt_o  = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_layer_mixer.sv
`default_nettype none
// ============================================================================
// Module   : tb_layer_mixer
// Purpose  : Self-checking bench for layer_mixer (vector table + scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
module tb_layer_mixer;

    localparam int NL = 4;
    localparam int RW = 12;
    localparam int CW = 4;
    localparam int NP = NL * NL;
    localparam logic [RW-1:0] BG = 12'h123;

    logic             clk_vga = 1'b0;
    logic             rst     = 1'b0;
    logic             disp_i  = 1'b0;
    logic             v_sync_i = 1'b1;
    logic [NL-1:0]    layer_en_i = '0;
    logic [NL*RW-1:0] rgb_i = '0;
    logic [NL-1:0]    alpha_i = '0;
    logic [RW-1:0]    rgb_o;
    logic             disp_o;
    logic [NP-1:0]    hit_pulse_o;
    logic [NP-1:0]    frame_hits_o;
    logic [CW-1:0]    frame_cnt_o;

    layer_mixer #(
        .NUM_LAYERS  (NL),
        .RGB_W       (RW),
        .BG_RGB      (BG),
        .FRAME_CNT_W (CW)
    ) dut (
        .clk_vga      (clk_vga),
        .rst          (rst),
        .disp_i       (disp_i),
        .v_sync_i     (v_sync_i),
        .layer_en_i   (layer_en_i),
        .rgb_i        (rgb_i),
        .alpha_i      (alpha_i),
        .rgb_o        (rgb_o),
        .disp_o       (disp_o),
        .hit_pulse_o  (hit_pulse_o),
        .frame_hits_o (frame_hits_o),
        .frame_cnt_o  (frame_cnt_o)
    );

    always #5 clk_vga = ~clk_vga;

    typedef struct {
        logic [NL-1:0]    en;
        logic [NL*RW-1:0] rgb;
        logic [NL-1:0]    alpha;
        logic             disp;
        logic [RW-1:0]    exp_rgb;
    } vec_t;

    typedef struct packed {
        logic [RW-1:0] rgb;
        logic          disp;
        logic [NP-1:0] pulse;
        logic [NP-1:0] fh;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t          sbq[$];
    vec_t          vecs[7];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            n_p02    = 0;
    int            n_p12    = 0;

    logic          m_prev_vs = 1'b1;
    logic [NP-1:0] m_seen    = '0;
    logic [NP-1:0] m_fh      = '0;
    logic [CW-1:0] m_cnt     = '0;

    function automatic logic [NL*RW-1:0] cols(input logic [RW-1:0] c3, c2, c1, c0);
        return {c3, c2, c1, c0};
    endfunction

    function automatic logic [RW-1:0] pix(input logic [NL-1:0] en, input logic [NL*RW-1:0] rgb,
                                          input logic [NL-1:0] alpha, input logic disp);
        logic [NL-1:0] o;
        o = alpha & en & {NL{disp}};
        if (!disp) return '0;
        for (int k = 0; k < NL; k++)
            if (o[k]) return rgb[k*RW +: RW];
        return BG;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".rgb_o"},        32'(rgb_o),        32'h0);
        check({tag, ".disp_o"},       32'(disp_o),       32'h0);
        check({tag, ".hit_pulse_o"},  32'(hit_pulse_o),  32'h0);
        check({tag, ".frame_hits_o"}, 32'(frame_hits_o), 32'h0);
        check({tag, ".frame_cnt_o"},  32'(frame_cnt_o),  32'h0);
    endtask

    // One pixel per call: compare the record issued two cycles ago, then
    // drive a new one and push its expected outputs.
    task automatic drive(input logic [NL-1:0] en, input logic [NL*RW-1:0] rgb,
                         input logic [NL-1:0] alpha, input logic disp, input logic vs,
                         input logic [RW-1:0] exp_rgb);
        exp_t          e;
        logic [NL-1:0] o;
        logic [NP-1:0] hn;
        logic          bnd;
        @(negedge clk_vga);
        if (sbq.size() >= 2) begin
            e = sbq.pop_front();
            check("rgb_o",        32'(rgb_o),        32'(e.rgb));
            check("disp_o",       32'(disp_o),       32'(e.disp));
            check("hit_pulse_o",  32'(hit_pulse_o),  32'(e.pulse));
            check("frame_hits_o", 32'(frame_hits_o), 32'(e.fh));
            check("frame_cnt_o",  32'(frame_cnt_o),  32'(e.cnt));
        end
        if (hit_pulse_o[0*NL+2]) n_p02++;
        if (hit_pulse_o[1*NL+2]) n_p12++;

        layer_en_i = en;
        rgb_i      = rgb;
        alpha_i    = alpha;
        disp_i     = disp;
        v_sync_i   = vs;

        o  = alpha & en & {NL{disp}};
        hn = '0;
        for (int i = 0; i < NL; i++)
            for (int j = i + 1; j < NL; j++)
                if (o[i] && o[j]) hn[i*NL+j] = 1'b1;
        bnd       = m_prev_vs & ~vs;
        m_prev_vs = vs;
        e.rgb   = exp_rgb;
        e.disp  = disp;
        e.pulse = hn & ~m_seen;
        if (bnd) begin
            m_fh   = m_seen | hn;
            m_seen = '0;
            m_cnt  = m_cnt + 1'b1;
        end else begin
            m_seen = m_seen | hn;
        end
        e.fh  = m_fh;
        e.cnt = m_cnt;
        sbq.push_back(e);
    endtask

    task automatic drive_m(input logic [NL-1:0] en, input logic [NL*RW-1:0] rgb,
                           input logic [NL-1:0] alpha, input logic disp, input logic vs);
        drive(en, rgb, alpha, disp, vs, pix(en, rgb, alpha, disp));
    endtask

    task automatic idle(input int n);
        repeat (n) drive_m('0, '0, '0, 1'b0, 1'b1);
    endtask

    task automatic frame_edge();
        drive_m('0, '0, '0, 1'b0, 1'b0);
        drive_m('0, '0, '0, 1'b0, 1'b0);
        drive_m('0, '0, '0, 1'b0, 1'b1);
    endtask

    task automatic do_reset(input int n, input string tag);
        @(negedge clk_vga);
        layer_en_i = '1;
        alpha_i    = '1;
        disp_i     = 1'b1;
        rgb_i      = cols(12'hF00, 12'h00F, 12'h0F0, 12'hFFF);
        #1 rst = 1'b0;
        #1 check_zero({tag, ".async"});
        repeat (n) @(negedge clk_vga);
        check_zero({tag, ".held"});
        disp_i     = 1'b0;
        alpha_i    = '0;
        layer_en_i = '0;
        v_sync_i   = 1'b1;
        sbq.delete();
        m_prev_vs = 1'b1;
        m_seen    = '0;
        m_fh      = '0;
        m_cnt     = '0;
        rst = 1'b1;
    endtask

    initial begin
        vecs[0] = '{4'hF, cols(12'hF00, 12'h00F, 12'h0F0, 12'hFFF), 4'b1010, 1'b1, 12'h0F0};
        vecs[1] = '{4'hF, cols(12'hF00, 12'h00F, 12'h0F0, 12'hFFF), 4'b0000, 1'b1, BG};
        vecs[2] = '{4'hF, cols(12'hF00, 12'h00F, 12'h0F0, 12'hFFF), 4'b1111, 1'b0, 12'h000};
        vecs[3] = '{4'hE, cols(12'hF00, 12'h00F, 12'h0F0, 12'hFFF), 4'b0101, 1'b1, 12'h00F};
        vecs[4] = '{4'hF, cols(12'hF00, 12'h00F, 12'h0F0, 12'hFFF), 4'b1000, 1'b1, 12'hF00};
        vecs[5] = '{4'hF, cols(12'hF00, 12'h00F, 12'h0F0, 12'hABC), 4'b1111, 1'b1, 12'hABC};
        vecs[6] = '{4'h0, cols(12'hF00, 12'h00F, 12'h0F0, 12'hABC), 4'b1111, 1'b1, BG};

        do_reset(3, "reset");

        for (int v = 0; v < 7; v++)
            drive(vecs[v].en, vecs[v].rgb, vecs[v].alpha, vecs[v].disp, 1'b1, vecs[v].exp_rgb);
        idle(3);
        frame_edge();
        idle(3);

        // Layers 0 and 2 overlap five times, separated by gaps.
        n_p02 = 0;
        for (int r = 0; r < 5; r++) begin
            drive_m(4'hF, cols(12'h000, 12'h00F, 12'h000, 12'hFFF), 4'b0101, 1'b1, 1'b1);
            idle(2);
        end
        idle(2);
        check("pulse02_count", 32'(n_p02), 32'd1);
        frame_edge();
        idle(3);
        check("fh02_after_frame", 32'(frame_hits_o[0*NL+2]), 32'd1);

        idle(4);
        frame_edge();
        idle(3);
        check("fh02_clean_frame", 32'(frame_hits_o[0*NL+2]), 32'd0);

        // Overlap of layers 1 and 2 on the exact boundary cycle.
        idle(2);
        n_p12 = 0;
        drive_m(4'hF, cols(12'h000, 12'h00F, 12'h0F0, 12'h000), 4'b0110, 1'b1, 1'b0);
        drive_m('0, '0, '0, 1'b0, 1'b0);
        idle(3);
        check("fh12_boundary", 32'(frame_hits_o[1*NL+2]), 32'd1);
        drive_m(4'hF, cols(12'h000, 12'h00F, 12'h0F0, 12'h000), 4'b0110, 1'b1, 1'b1);
        idle(3);
        check("pulse12_count", 32'(n_p12), 32'd2);

        // Counter wrap over 17 frames at a 4-bit counter width.
        do_reset(2, "reset2");
        for (int f = 0; f < 17; f++) begin
            frame_edge();
            idle(2);
        end
        idle(2);
        check("cnt_wrap", 32'(frame_cnt_o), 32'd1);

        // Mid-frame reset discards the partial frame's hits.
        drive_m(4'hF, cols(12'h000, 12'h000, 12'h0F0, 12'hFFF), 4'b0011, 1'b1, 1'b1);
        idle(1);
        do_reset(2, "reset3");
        idle(4);
        frame_edge();
        idle(3);
        check("fh_after_reset", 32'(frame_hits_o), 32'd0);
        check("cnt_after_reset", 32'(frame_cnt_o), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
